pn_token_feeder: RTL and testbench

- Upstream stage of the Polish-notation calculator.
- Accepts a host token stream (valid/ready, one token per cycle, expression delimited by last), buffers it, and validates each expression's length and mode.
- Replays each valid expression to the calculator as one contiguous in_valid burst, then waits for the calculator's result pulses before starting the next expression.
- Malformed expressions are dropped without being sent and reported through an error code.

---
 rtl/pn_pkg.sv | 33 +++
 rtl/pn_token_feeder_if.sv | 25 ++
 rtl/pn_sync_fifo.sv | 45 ++++
 rtl/pn_token_feeder.sv | 170 +++++++++++++++++
 tb/tb_pn_token_feeder.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/pn_pkg.sv
// pn_pkg: shared types and constants for the PN token feeder
package pn_pkg;
   localparam int LEN_W = 4;
   typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_DROP, S_GAP} state_t;
   localparam logic [1:0] ERR_OK = 2'd0;
   localparam logic [1:0] ERR_LONG = 2'd1;
   localparam logic [1:0] ERR_SHORT = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;
   localparam logic [1:0] PRE_SORT_DESC = 2'd0;
   localparam logic [1:0] POST_SORT_ASC = 2'd1;
   localparam logic [1:0] PRE_STACK = 2'd2;
   localparam logic [1:0] POST_STACK = 2'd3;
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_ABS = 3'd3;
   typedef struct packed {
      logic       op;
      logic [2:0] data;
   } tok_t;
   typedef struct packed {
      logic             ovf;
      logic [1:0]       mode;
      logic [LEN_W-1:0] len;
   } desc_t;
   function automatic logic is_sort(input logic [1:0] mode);
      return mode == PRE_SORT_DESC || mode == POST_SORT_ASC;
   endfunction
   // sort modes yield one result per operand/operand/operator triple; stack modes yield one
   function automatic logic [2:0] exp_of(input logic [1:0] mode, input logic [LEN_W-1:0] len);
      return (mode == PRE_STACK || mode == POST_STACK) ? 3'd1 : 3'(len / LEN_W'(3));
   endfunction
endpackage

// File: rtl/pn_token_feeder_if.sv
// pn_token_feeder_if: host token stream, calculator link and status of the feeder
interface pn_token_feeder_if;
   logic       s_valid;
   logic       s_ready;
   logic       s_operator;
   logic [2:0] s_data;
   logic [1:0] s_mode;
   logic       s_last;
   logic [1:0] pn_mode;
   logic       pn_operator;
   logic [2:0] pn_in;
   logic       pn_in_valid;
   logic       pn_out_valid;
   logic       done;
   logic [1:0] err;
   logic [2:0] res_cnt;
   modport master (
      output s_valid, s_operator, s_data, s_mode, s_last, pn_out_valid,
      input  s_ready, pn_mode, pn_operator, pn_in, pn_in_valid, done, err, res_cnt
   );
   modport slave (
      input  s_valid, s_operator, s_data, s_mode, s_last, pn_out_valid,
      output s_ready, pn_mode, pn_operator, pn_in, pn_in_valid, done, err, res_cnt
   );
endinterface

// File: rtl/pn_sync_fifo.sv
// pn_sync_fifo: show-ahead synchronous FIFO with same-cycle push and pop
module pn_sync_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic wr_en, rd_en;
   always_comb begin
      full = cnt_q == CW'(DEPTH);
      empty = cnt_q == '0;
      wr_en = push && !full;
      rd_en = pop && !empty;
      wr_d = !wr_en ? wr_q : (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
      rd_d = !rd_en ? rd_q : (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
      cnt_d = cnt_q + CW'(wr_en) - CW'(rd_en);
      pop_data = mem_q[rd_q];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_q] <= push_data;
   end
endmodule

// File: rtl/pn_token_feeder.sv
// pn_token_feeder: buffers host expressions, validates them and replays each as one burst to the PN calculator
module pn_token_feeder
   import pn_pkg::*;
#(
   parameter int MAX_TOKENS = 12,
   parameter int DEPTH = 16,
   parameter int LEN_DEPTH = 4,
   parameter int TIMEOUT = 256
) (
   input logic clk,
   input logic rst,
   pn_token_feeder_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_TOKENS);
   logic tok_full, tok_empty, len_full, len_empty;
   logic tok_push, tok_pop, len_push, len_pop;
   logic s_ready, acc, at_max;
   logic [1:0] cur_mode;
   tok_t tok_in, tok_out;
   desc_t desc_in, desc_out;
   logic [LEN_W-1:0] in_len_q, in_len_d;
   logic ovf_q, ovf_d;
   logic [1:0] in_mode_q, in_mode_d;
   state_t state_q, state_d;
   logic [1:0] mode_q, mode_d, err_q, err_d, err_o_q, err_o_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [2:0] exp_q, exp_d, res_q, res_d, res_o_q, res_o_d, res_inc;
   logic [TW-1:0] timer_q, timer_d;
   logic gap_q, gap_d, pv_q, pv_d, pop_q, pop_d, done_q, done_d;
   logic [2:0] pin_q, pin_d;
   pn_sync_fifo #(.WIDTH($bits(tok_t)), .DEPTH(DEPTH)) u_tok_fifo (
      .clk(clk), .rst(rst), .push(tok_push), .push_data(tok_in), .pop(tok_pop),
      .pop_data(tok_out), .full(tok_full), .empty(tok_empty)
   );
   pn_sync_fifo #(.WIDTH($bits(desc_t)), .DEPTH(LEN_DEPTH)) u_len_fifo (
      .clk(clk), .rst(rst), .push(len_push), .push_data(desc_in), .pop(len_pop),
      .pop_data(desc_out), .full(len_full), .empty(len_empty)
   );
   assign s_ready = !tok_full && !len_full;
   assign bus.s_ready = s_ready;
   assign bus.pn_mode = mode_q;
   assign bus.pn_operator = pop_q;
   assign bus.pn_in = pin_q;
   assign bus.pn_in_valid = pv_q;
   assign bus.done = done_q;
   assign bus.err = err_o_q;
   assign bus.res_cnt = res_o_q;
   // tokens past MAX_TOKENS are still accepted so the host never stalls, but only flag overflow
   always_comb begin
      acc = bus.s_valid && s_ready;
      at_max = in_len_q == MAX_LEN;
      cur_mode = (in_len_q == '0) ? bus.s_mode : in_mode_q;
      tok_push = acc && !at_max;
      tok_in = '{op: bus.s_operator, data: bus.s_data};
      len_push = acc && bus.s_last;
      desc_in = '{ovf: ovf_q || at_max, mode: cur_mode, len: at_max ? MAX_LEN : in_len_q + LEN_W'(1)};
      in_len_d = in_len_q;
      ovf_d = ovf_q;
      in_mode_d = in_mode_q;
      if (acc) begin
         in_mode_d = cur_mode;
         in_len_d = bus.s_last ? '0 : at_max ? in_len_q : in_len_q + LEN_W'(1);
         ovf_d = !bus.s_last && (ovf_q || at_max);
      end
   end
   always_comb begin
      state_d = state_q;
      mode_d = mode_q;
      rem_d = rem_q;
      exp_d = exp_q;
      timer_d = timer_q;
      res_d = res_q;
      err_d = err_q;
      gap_d = gap_q;
      pv_d = 1'b0;
      pin_d = pin_q;
      pop_d = pop_q;
      done_d = 1'b0;
      err_o_d = ERR_OK;
      res_o_d = '0;
      len_pop = 1'b0;
      tok_pop = 1'b0;
      res_inc = (res_q == 3'd7) ? 3'd7 : res_q + {2'b0, bus.pn_out_valid};
      case (state_q)
         S_IDLE: if (!len_empty) begin
            len_pop = 1'b1;
            mode_d = desc_out.mode;
            rem_d = desc_out.len;
            exp_d = exp_of(desc_out.mode, desc_out.len);
            timer_d = '0;
            res_d = '0;
            err_d = desc_out.ovf ? ERR_LONG : ERR_SHORT;
            state_d = (desc_out.ovf || (is_sort(desc_out.mode) && desc_out.len < LEN_W'(3))) ? S_DROP : S_SEND;
         end
         S_SEND: begin
            tok_pop = 1'b1;
            pv_d = 1'b1;
            pin_d = tok_out.data;
            pop_d = tok_out.op;
            rem_d = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) state_d = S_WAIT;
         end
         S_WAIT: begin
            timer_d = timer_q + TW'(1);
            res_d = res_inc;
            if (res_inc == exp_q || timer_q == TW'(TIMEOUT - 1)) begin
               state_d = S_GAP;
               gap_d = 1'b0;
               done_d = 1'b1;
               err_o_d = (res_inc == exp_q) ? ERR_OK : ERR_TIMEOUT;
               res_o_d = res_inc;
            end
         end
         S_DROP: begin
            tok_pop = 1'b1;
            rem_d = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
               state_d = S_IDLE;
               done_d = 1'b1;
               err_o_d = err_q;
            end
         end
         S_GAP: begin
            gap_d = 1'b1;
            if (gap_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         in_len_q <= '0;
         ovf_q <= 1'b0;
         in_mode_q <= '0;
         state_q <= S_IDLE;
         mode_q <= '0;
         rem_q <= '0;
         exp_q <= '0;
         timer_q <= '0;
         res_q <= '0;
         err_q <= ERR_OK;
         gap_q <= 1'b0;
         pv_q <= 1'b0;
         pin_q <= '0;
         pop_q <= 1'b0;
         done_q <= 1'b0;
         err_o_q <= ERR_OK;
         res_o_q <= '0;
      end else begin
         in_len_q <= in_len_d;
         ovf_q <= ovf_d;
         in_mode_q <= in_mode_d;
         state_q <= state_d;
         mode_q <= mode_d;
         rem_q <= rem_d;
         exp_q <= exp_d;
         timer_q <= timer_d;
         res_q <= res_d;
         err_q <= err_d;
         gap_q <= gap_d;
         pv_q <= pv_d;
         pin_q <= pin_d;
         pop_q <= pop_d;
         done_q <= done_d;
         err_o_q <= err_o_d;
         res_o_q <= res_o_d;
      end
   end
endmodule

// File: tb/tb_pn_token_feeder.sv
// tb_pn_token_feeder: directed checks of burst replay, drop, timeout and reset behaviour
module tb_pn_token_feeder;
   import pn_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int cyc = 0, total = 0, bad = 0, hs = 0, pc = 0, stalls = 0;
   int tok_cyc[$];
   logic [5:0] tok_val[$];
   int done_cyc[$];
   logic [4:0] done_val[$];
   pn_token_feeder_if bus();
   pn_token_feeder dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (bus.pn_in_valid) begin
         tok_cyc.push_back(cyc);
         tok_val.push_back({bus.pn_mode, bus.pn_operator, bus.pn_in});
      end
      if (bus.done) begin
         done_cyc.push_back(cyc);
         done_val.push_back({bus.err, bus.res_cnt});
      end
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask
   task automatic put(input logic op, input logic [2:0] d, input logic [1:0] m, input logic l);
      int n = 0;
      bus.s_valid = 1'b1;
      bus.s_operator = op;
      bus.s_data = d;
      bus.s_mode = m;
      bus.s_last = l;
      while (!bus.s_ready && n < 300) begin
         step(1);
         n++;
      end
      stalls += n;
      if (!bus.s_ready) chk("put_ready", 32'(bus.s_ready), 1);
      hs = cyc;
      step(1);
      bus.s_valid = 1'b0;
      bus.s_last = 1'b0;
   endtask
   task automatic send(input int n, input logic [1:0] m, input logic [15:0] ops, input logic [47:0] dat);
      for (int i = 0; i < n; i++) put(ops[i], dat[3*i+:3], m, i == n - 1);
   endtask
   task automatic wait_toks(input int n);
      int k = 0;
      while (tok_cyc.size() < n && k < 400) begin
         step(1);
         k++;
      end
      if (tok_cyc.size() < n) chk("tok_timeout", tok_cyc.size(), n);
   endtask
   task automatic wait_done(input int n);
      int k = 0;
      while (done_cyc.size() < n && k < 400) begin
         step(1);
         k++;
      end
      if (done_cyc.size() < n) chk("done_timeout", done_cyc.size(), n);
   endtask
   task automatic pulse();
      bus.pn_out_valid = 1'b1;
      pc = cyc;
      step(1);
      bus.pn_out_valid = 1'b0;
   endtask
   task automatic clr();
      tok_cyc.delete();
      tok_val.delete();
      done_cyc.delete();
      done_val.delete();
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
   initial begin
      bus.s_valid = 1'b0;
      bus.s_operator = 1'b0;
      bus.s_data = '0;
      bus.s_mode = '0;
      bus.s_last = 1'b0;
      bus.pn_out_valid = 1'b0;
      step(3);
      rst = 1'b0;
      step(1);
      chk("rst_ready", 32'(bus.s_ready), 1);
      chk("rst_pv", 32'(bus.pn_in_valid), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_err", 32'(bus.err), 0);
      chk("rst_res", 32'(bus.res_cnt), 0);
      chk("rst_mode", 32'(bus.pn_mode), 0);
      clr();
      send(3, POST_STACK, 16'b100, 48'({OP_ADD, 3'd4, 3'd3}));
      wait_toks(3);
      step(2);
      chk("t1_len", tok_cyc.size(), 3);
      chk("t1_lat", tok_cyc[0] - hs, 3);
      chk("t1_burst", tok_cyc[2] - tok_cyc[0], 2);
      chk("t1_tok0", 32'(tok_val[0]), 32'({POST_STACK, 1'b0, 3'd3}));
      chk("t1_tok1", 32'(tok_val[1]), 32'({POST_STACK, 1'b0, 3'd4}));
      chk("t1_tok2", 32'(tok_val[2]), 32'({POST_STACK, 1'b1, OP_ADD}));
      chk("t1_nodone", done_cyc.size(), 0);
      pulse();
      wait_done(1);
      chk("t1_done_lat", done_cyc[0] - pc, 1);
      chk("t1_status", 32'(done_val[0]), 32'({ERR_OK, 3'd1}));
      step(5);
      clr();
      send(6, PRE_SORT_DESC, 16'b11, 48'({3'd4, 3'd3, 3'd2, 3'd1, OP_MUL, OP_ADD}));
      wait_toks(6);
      step(1);
      chk("t2_len", tok_cyc.size(), 6);
      chk("t2_burst", tok_cyc[5] - tok_cyc[0], 5);
      chk("t2_tok1", 32'(tok_val[1]), 32'({PRE_SORT_DESC, 1'b1, OP_MUL}));
      chk("t2_tok5", 32'(tok_val[5]), 32'({PRE_SORT_DESC, 1'b0, 3'd4}));
      pulse();
      pulse();
      wait_done(1);
      chk("t2_done_lat", done_cyc[0] - pc, 1);
      chk("t2_status", 32'(done_val[0]), 32'({ERR_OK, 3'd2}));
      pulse();
      step(6);
      chk("t2_late", done_cyc.size(), 1);
      clr();
      send(2, POST_SORT_ASC, 16'b0, 48'({3'd2, 3'd1}));
      wait_done(1);
      step(3);
      chk("t3_notok", tok_cyc.size(), 0);
      chk("t3_done_lat", done_cyc[0] - hs, 4);
      chk("t3_status", 32'(done_val[0]), 32'({ERR_SHORT, 3'd0}));
      clr();
      send(3, PRE_STACK, 16'b100, 48'({OP_SUB, 3'd2, 3'd5}));
      wait_toks(3);
      chk("t3b_lat", tok_cyc[0] - hs, 3);
      chk("t3b_tok0", 32'(tok_val[0]), 32'({PRE_STACK, 1'b0, 3'd5}));
      pulse();
      wait_done(1);
      chk("t3b_status", 32'(done_val[0]), 32'({ERR_OK, 3'd1}));
      step(5);
      clr();
      stalls = 0;
      send(14, PRE_SORT_DESC, 16'h0, 48'h0);
      chk("t4_stalls", stalls, 0);
      wait_done(1);
      step(3);
      chk("t4_notok", tok_cyc.size(), 0);
      chk("t4_done_lat", done_cyc[0] - hs, 14);
      chk("t4_status", 32'(done_val[0]), 32'({ERR_LONG, 3'd0}));
      clr();
      send(3, PRE_STACK, 16'b100, 48'({OP_MUL, 3'd2, 3'd1}));
      wait_toks(3);
      wait_done(1);
      chk("t5_to_lat", done_cyc[0] - tok_cyc[2], 256);
      chk("t5_status", 32'(done_val[0]), 32'({ERR_TIMEOUT, 3'd0}));
      step(5);
      clr();
      send(3, POST_STACK, 16'b100, 48'({OP_ADD, 3'd1, 3'd2}));
      send(3, POST_STACK, 16'b100, 48'({OP_SUB, 3'd3, 3'd4}));
      send(3, POST_STACK, 16'b100, 48'({OP_ABS, 3'd5, 3'd6}));
      wait_toks(3);
      pulse();
      wait_done(1);
      chk("t6_a_status", 32'(done_val[0]), 32'({ERR_OK, 3'd1}));
      wait_toks(4);
      rst = 1'b1;
      step(1);
      chk("t6_rst_pv", 32'(bus.pn_in_valid), 0);
      chk("t6_rst_done", 32'(bus.done), 0);
      rst = 1'b0;
      step(1);
      chk("t6_ready", 32'(bus.s_ready), 1);
      step(10);
      chk("t6_toks", tok_cyc.size(), 5);
      chk("t6_nodone", done_cyc.size(), 1);
      clr();
      send(3, POST_STACK, 16'b100, 48'({OP_ADD, 3'd1, 3'd6}));
      wait_toks(3);
      chk("t6_new_lat", tok_cyc[0] - hs, 3);
      chk("t6_new_tok0", 32'(tok_val[0]), 32'({POST_STACK, 1'b0, 3'd6}));
      pulse();
      wait_done(1);
      chk("t6_new_status", 32'(done_val[0]), 32'({ERR_OK, 3'd1}));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
